// File: rtl/register_file_param.sv
// Parametrised 2-read/1-write register file with write-first bypass, per-entry valid bits,
// optional registered read ports and a sequential clear engine that zeroes every entry.
module register_file_param #(
    parameter int N       = 16,
    parameter int A       = 4,
    parameter int REG_RD  = 0,
    parameter int ZERO_R0 = 0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [A-1:0] w_addr,
    input  logic [N-1:0] w_data,
    input  logic         w_en,
    input  logic [A-1:0] ra_addr,
    input  logic         ra_en,
    input  logic [A-1:0] rb_addr,
    input  logic         rb_en,
    input  logic         clr_req,
    output logic         clr_busy,
    output logic [N-1:0] ra_data,
    output logic [N-1:0] rb_data,
    output logic         ra_valid,
    output logic         rb_valid
);

    localparam int D = 1 << A;

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    state_t         state_q, state_d;
    logic [A-1:0]   ptr_q, ptr_d;
    logic [N-1:0]   mem_q [D];
    logic [D-1:0]   valid_q;
    logic           wr_accept;
    logic [N-1:0]   ra_data_d, rb_data_d;
    logic           ra_valid_d, rb_valid_d;

    assign clr_busy  = (state_q == SWEEP);
    assign wr_accept = w_en && !clr_busy && !reset &&
                       !((ZERO_R0 != 0) && (w_addr == '0));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // The sweep ends after clearing the last entry; the pointer rolls back to 0 there.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = SWEEP;
                    ptr_d   = '0;
                end
            end
            SWEEP: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == {A{1'b1}}) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < D; i++) begin
                mem_q[i] <= '0;
            end
            valid_q <= '0;
        end else if (state_q == SWEEP) begin
            mem_q[ptr_q]   <= '0;
            valid_q[ptr_q] <= 1'b0;
        end else if (wr_accept) begin
            mem_q[w_addr]   <= w_data;
            valid_q[w_addr] <= 1'b1;
        end
    end

    // Write-first: an accepted write to the addressed entry is forwarded to the port.
    always_comb begin
        ra_data_d  = '0;
        ra_valid_d = 1'b0;
        rb_data_d  = '0;
        rb_valid_d = 1'b0;
        if (ra_en) begin
            if (wr_accept && (w_addr == ra_addr)) begin
                ra_data_d  = w_data;
                ra_valid_d = 1'b1;
            end else begin
                ra_data_d  = mem_q[ra_addr];
                ra_valid_d = valid_q[ra_addr];
            end
        end
        if (rb_en) begin
            if (wr_accept && (w_addr == rb_addr)) begin
                rb_data_d  = w_data;
                rb_valid_d = 1'b1;
            end else begin
                rb_data_d  = mem_q[rb_addr];
                rb_valid_d = valid_q[rb_addr];
            end
        end
    end

    generate
        if (REG_RD != 0) begin : g_reg_rd
            logic [N-1:0] ra_data_q, rb_data_q;
            logic         ra_valid_q, rb_valid_q;

            always_ff @(posedge clock) begin
                if (reset) begin
                    ra_data_q  <= '0;
                    rb_data_q  <= '0;
                    ra_valid_q <= 1'b0;
                    rb_valid_q <= 1'b0;
                end else begin
                    ra_data_q  <= ra_data_d;
                    rb_data_q  <= rb_data_d;
                    ra_valid_q <= ra_valid_d;
                    rb_valid_q <= rb_valid_d;
                end
            end

            assign ra_data  = ra_data_q;
            assign rb_data  = rb_data_q;
            assign ra_valid = ra_valid_q;
            assign rb_valid = rb_valid_q;
        end else begin : g_comb_rd
            assign ra_data  = ra_data_d;
            assign rb_data  = rb_data_d;
            assign ra_valid = ra_valid_d;
            assign rb_valid = rb_valid_d;
        end
    endgenerate

endmodule

// File: tb/tb_register_file_param.sv
// Drives a combinational-read instance and a registered-read/zero-r0 instance with the same
// stimulus and compares both against a per-entry array model of the register file.
module tb_register_file_param;

    localparam int N = 16;
    localparam int A = 4;
    localparam int D = 16;

    logic         clock = 1'b0;
    logic         reset;
    logic [A-1:0] wAddr, raAddr, rbAddr;
    logic [N-1:0] wData;
    logic         wEn, raEn, rbEn, clrReq;

    logic         busy0, raValid0, rbValid0;
    logic [N-1:0] raData0, rbData0;
    logic         busy1, raValid1, rbValid1;
    logic [N-1:0] raData1, rbData1;

    int compared   = 0;
    int mismatched = 0;

    // Model state: index 0 is the plain file, index 1 has register 0 hard-wired to zero.
    logic [N-1:0] mMem [2][D];
    bit           mVld [2][D];
    int           mSweep [2];
    logic [N-1:0] regA1Data, regB1Data;
    logic         regA1Valid, regB1Valid;
    bit           checkOn;

    always #5 clock = ~clock;

    register_file_param #(.N(N), .A(A), .REG_RD(0), .ZERO_R0(0)) dutComb (
        .clock(clock), .reset(reset),
        .w_addr(wAddr), .w_data(wData), .w_en(wEn),
        .ra_addr(raAddr), .ra_en(raEn), .rb_addr(rbAddr), .rb_en(rbEn),
        .clr_req(clrReq), .clr_busy(busy0),
        .ra_data(raData0), .rb_data(rbData0), .ra_valid(raValid0), .rb_valid(rbValid0)
    );

    register_file_param #(.N(N), .A(A), .REG_RD(1), .ZERO_R0(1)) dutReg (
        .clock(clock), .reset(reset),
        .w_addr(wAddr), .w_data(wData), .w_en(wEn),
        .ra_addr(raAddr), .ra_en(raEn), .rb_addr(rbAddr), .rb_en(rbEn),
        .clr_req(clrReq), .clr_busy(busy1),
        .ra_data(raData1), .rb_data(rbData1), .ra_valid(raValid1), .rb_valid(rbValid1)
    );

    function automatic bit accepts(int m);
        return !reset && wEn && (mSweep[m] < 0) && !(m == 1 && wAddr == 4'd0);
    endfunction

    task automatic expectPort(input int m, input logic [A-1:0] addr, input logic en,
                              output logic [N-1:0] d, output logic v);
        if (!en) begin
            d = '0;
            v = 1'b0;
        end else if (accepts(m) && wAddr == addr) begin
            d = wData;
            v = 1'b1;
        end else begin
            d = mMem[m][addr];
            v = mVld[m][addr];
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare outputs mid-cycle, then advance the model at the rising edge.
    task automatic applyStimulus(input string tag);
        logic [N-1:0] ea0, eb0, ea1, eb1;
        logic         va0, vb0, va1, vb1;
        #4;
        expectPort(0, raAddr, raEn, ea0, va0);
        expectPort(0, rbAddr, rbEn, eb0, vb0);
        expectPort(1, raAddr, raEn, ea1, va1);
        expectPort(1, rbAddr, rbEn, eb1, vb1);
        if (checkOn) begin
            checkOutput({tag, "/comb.ra_data"},  32'(raData0),  32'(ea0));
            checkOutput({tag, "/comb.ra_valid"}, 32'(raValid0), 32'(va0));
            checkOutput({tag, "/comb.rb_data"},  32'(rbData0),  32'(eb0));
            checkOutput({tag, "/comb.rb_valid"}, 32'(rbValid0), 32'(vb0));
            checkOutput({tag, "/comb.clr_busy"}, 32'(busy0),    32'(mSweep[0] >= 0));
            checkOutput({tag, "/reg.ra_data"},   32'(raData1),  32'(regA1Data));
            checkOutput({tag, "/reg.ra_valid"},  32'(raValid1), 32'(regA1Valid));
            checkOutput({tag, "/reg.rb_data"},   32'(rbData1),  32'(regB1Data));
            checkOutput({tag, "/reg.rb_valid"},  32'(rbValid1), 32'(regB1Valid));
            checkOutput({tag, "/reg.clr_busy"},  32'(busy1),    32'(mSweep[1] >= 0));
        end
        @(posedge clock);
        if (reset) begin
            regA1Data = '0; regB1Data = '0; regA1Valid = 1'b0; regB1Valid = 1'b0;
        end else begin
            regA1Data = ea1; regB1Data = eb1; regA1Valid = va1; regB1Valid = vb1;
        end
        for (int m = 0; m < 2; m++) begin
            if (reset) begin
                for (int i = 0; i < D; i++) begin
                    mMem[m][i] = '0;
                    mVld[m][i] = 1'b0;
                end
                mSweep[m] = -1;
            end else if (mSweep[m] >= 0) begin
                mMem[m][mSweep[m]] = '0;
                mVld[m][mSweep[m]] = 1'b0;
                mSweep[m] = (mSweep[m] == D - 1) ? -1 : mSweep[m] + 1;
            end else begin
                if (accepts(m)) begin
                    mMem[m][wAddr] = wData;
                    mVld[m][wAddr] = 1'b1;
                end
                if (clrReq) mSweep[m] = 0;
            end
        end
        #1;
    endtask

    initial begin
        $display("[TB] starting register_file_param bench");
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < D; i++) begin
                mMem[m][i] = '0;
                mVld[m][i] = 1'b0;
            end
            mSweep[m] = -1;
        end
        regA1Data = '0; regB1Data = '0; regA1Valid = 1'b0; regB1Valid = 1'b0;
        checkOn = 1'b0;

        // Reset with both ports reading entry 5.
        reset = 1'b1; wEn = 1'b0; wAddr = '0; wData = '0; clrReq = 1'b0;
        raEn = 1'b1; rbEn = 1'b1; raAddr = 4'd5; rbAddr = 4'd5;
        applyStimulus("init");
        checkOn = 1'b1;
        applyStimulus("reset");
        reset = 1'b0;
        applyStimulus("reset_rel");

        // Write with same-cycle read of the same entry, then hold, then disable port A.
        wEn = 1'b1; wAddr = 4'd3; wData = 16'hBEEF; raAddr = 4'd3; rbAddr = 4'd3;
        applyStimulus("bypass");
        wEn = 1'b0;
        applyStimulus("hold");
        raEn = 1'b0;
        applyStimulus("ra_off");
        raEn = 1'b1;

        // Fill every entry, then read them back in opposite orders on the two ports.
        for (int i = 0; i < D; i++) begin
            wEn = 1'b1; wAddr = 4'(i); wData = 16'(16'h1000 + i);
            raAddr = 4'(i); rbAddr = 4'(D - 1 - i);
            applyStimulus("fill");
        end
        wEn = 1'b0;
        for (int i = 0; i < D + 1; i++) begin
            raAddr = 4'(i); rbAddr = 4'(D - 1 - i);
            applyStimulus("readback");
        end

        // Clear sweep with a rejected mid-sweep write and an ignored second request.
        clrReq = 1'b1;
        applyStimulus("clr_start");
        clrReq = 1'b0;
        for (int i = 0; i < D; i++) begin
            wEn = (i == 5); wAddr = 4'd7; wData = 16'h5555;
            clrReq = (i == 9);
            raAddr = 4'(i); rbAddr = 4'd7;
            applyStimulus("sweep");
        end
        wEn = 1'b0; clrReq = 1'b0;
        for (int i = 0; i < D; i++) begin
            raAddr = 4'(i); rbAddr = 4'(i);
            applyStimulus("after_clr");
        end

        // Reset on the seventh busy cycle, then a fresh sweep must still work.
        for (int i = 0; i < 4; i++) begin
            wEn = 1'b1; wAddr = 4'(i + 8); wData = 16'(16'hA0A0 + i);
            applyStimulus("prefill");
        end
        wEn = 1'b0; clrReq = 1'b1;
        applyStimulus("clr2_start");
        clrReq = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            reset = (i == 7);
            raAddr = 4'(i + 7); rbAddr = 4'd11;
            applyStimulus("mid_sweep");
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            raAddr = 4'(i + 8); rbAddr = 4'(i);
            applyStimulus("post_reset");
        end
        clrReq = 1'b1;
        applyStimulus("clr3_start");
        clrReq = 1'b0;
        for (int i = 0; i < D + 2; i++) applyStimulus("clr3");

        // Register 0 writes and a registered read of entry 2.
        wEn = 1'b1; wAddr = 4'd0; wData = 16'hFFFF; raAddr = 4'd0; rbAddr = 4'd0;
        applyStimulus("r0_write");
        wEn = 1'b0;
        applyStimulus("r0_read");
        applyStimulus("r0_read2");
        wEn = 1'b1; wAddr = 4'd2; wData = 16'h1234; raAddr = 4'd2; rbAddr = 4'd0;
        applyStimulus("r2_write");
        wEn = 1'b0;
        applyStimulus("r2_read");
        applyStimulus("r2_read2");

        // Randomised traffic including occasional clears, resets and shared addresses.
        for (int i = 0; i < 400; i++) begin
            reset  = ($urandom_range(0, 99) == 0);
            clrReq = ($urandom_range(0, 29) == 0);
            wEn    = ($urandom_range(0, 1) == 1);
            wAddr  = 4'($urandom_range(0, 15));
            wData  = 16'($urandom);
            raEn   = ($urandom_range(0, 3) != 0);
            rbEn   = ($urandom_range(0, 3) != 0);
            raAddr = ($urandom_range(0, 2) == 0) ? wAddr : 4'($urandom_range(0, 15));
            rbAddr = ($urandom_range(0, 3) == 0) ? raAddr : 4'($urandom_range(0, 15));
            applyStimulus("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
